// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle for the iterative multiply/divide unit.
// master = pipeline side (issues requests, consumes results); slave = the unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             div_by_zero;

  modport master (
    output in_valid, op, x, y, kill, out_ready,
    input  in_ready, out_valid, lo, hi, div_by_zero
  );

  modport slave (
    input  in_valid, op, x, y, kill, out_ready,
    output in_ready, out_valid, lo, hi, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 shift-add multiplier and restoring divider.
// op: 0 = MUL signed, 1 = DIVU, 2 = DIV signed (only with MULDIV_SIGNED_DIV_EN,
// otherwise aliases DIVU), 3 = treated as MUL.
// Optional build macro: MULDIV_SIGNED_DIV_EN.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;   // product high half / partial remainder
  logic [WIDTH-1:0] sh;    // product low half (multiplier) / dividend shifting into quotient
  logic [WIDTH-1:0] opd;   // multiplicand / divisor
  logic             neg_res;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             dbz_q;
`ifdef MULDIV_SIGNED_DIV_EN
  logic             sdiv;
  logic             neg_rem;
`endif

  logic               accept;
  logic               req_div;
  logic               prep;
  logic               last;
  logic               div_zero;
  logic               fits;
  logic [WIDTH-1:0]   mag_sh;
  logic [WIDTH-1:0]   mag_opd;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   mul_acc;
  logic [WIDTH-1:0]   mul_sh;
  logic [WIDTH-1:0]   div_acc;
  logic [WIDTH-1:0]   div_sh;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod;

  assign accept   = bus.in_valid && (state == IDLE) && !bus.kill;
  assign req_div  = (bus.op == 2'd1) || (bus.op == 2'd2);
  // The counter is loaded with all ones on accept; that value marks the
  // operand-preparation cycle and wraps to zero for the first iteration.
  assign prep     = (count == '1);
  assign last     = (count == CNT_W'(WIDTH - 1));
  assign div_zero = (state == DIV) && prep && (opd == '0);

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.lo          = lo_q;
  assign bus.hi          = hi_q;
  assign bus.div_by_zero = dbz_q;

  // One iteration step of both algorithms plus final sign correction.
  always_comb begin
    mag_sh   = sh[WIDTH-1] ? -sh : sh;
    mag_opd  = opd[WIDTH-1] ? -opd : opd;

    mul_sum  = {1'b0, acc} + (sh[0] ? {1'b0, opd} : '0);
    mul_acc  = mul_sum[WIDTH:1];
    mul_sh   = {mul_sum[0], sh[WIDTH-1:1]};
    prod_raw = {mul_acc, mul_sh};
    prod     = neg_res ? -prod_raw : prod_raw;

    trial    = {acc, sh[WIDTH-1]} - {1'b0, opd};
    fits     = !trial[WIDTH];
    div_acc  = fits ? trial[WIDTH-1:0] : {acc[WIDTH-2:0], sh[WIDTH-1]};
    div_sh   = {sh[WIDTH-2:0], fits};

    div_q    = div_sh;
    div_r    = div_acc;
`ifdef MULDIV_SIGNED_DIV_EN
    if (sdiv && neg_res) div_q = -div_sh;
    if (sdiv && neg_rem) div_r = -div_acc;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; kill overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = req_div ? DIV : MUL;
      MUL:  if (last) state_next = DONE;
      DIV:  if (div_zero || last) state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.kill) state_next = IDLE;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      acc     <= '0;
      sh      <= '0;
      opd     <= '0;
      neg_res <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dbz_q   <= 1'b0;
`ifdef MULDIV_SIGNED_DIV_EN
      sdiv    <= 1'b0;
      neg_rem <= 1'b0;
`endif
    end else if (!bus.kill) begin
      case (state)
        IDLE: begin
          if (accept) begin
            count <= '1;
            acc   <= '0;
            sh    <= req_div ? bus.x : bus.y;
            opd   <= req_div ? bus.y : bus.x;
`ifdef MULDIV_SIGNED_DIV_EN
            sdiv  <= (bus.op == 2'd2);
`endif
          end
        end
        MUL: begin
          if (prep) begin
            sh      <= mag_sh;
            opd     <= mag_opd;
            neg_res <= sh[WIDTH-1] ^ opd[WIDTH-1];
            count   <= '0;
          end else begin
            acc   <= mul_acc;
            sh    <= mul_sh;
            count <= count + CNT_W'(1);
            if (last) begin
              lo_q  <= prod[WIDTH-1:0];
              hi_q  <= prod[2*WIDTH-1:WIDTH];
              dbz_q <= 1'b0;
            end
          end
        end
        DIV: begin
          if (div_zero) begin
            lo_q  <= '1;
            hi_q  <= sh;
            dbz_q <= 1'b1;
          end else if (prep) begin
            count <= '0;
`ifdef MULDIV_SIGNED_DIV_EN
            if (sdiv) begin
              sh  <= mag_sh;
              opd <= mag_opd;
            end
            neg_res <= sh[WIDTH-1] ^ opd[WIDTH-1];
            neg_rem <= sh[WIDTH-1];
`endif
          end else begin
            acc   <= div_acc;
            sh    <= div_sh;
            count <= count + CNT_W'(1);
            if (last) begin
              lo_q  <= div_q;
              hi_q  <= div_r;
              dbz_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one clock; the DUT must be idle.
  task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.x        = x;
    bus.y        = y;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Count edges until out_valid, bounded; a timeout shows as a latency mismatch.
  task automatic wait_valid(input string tag, input int unsigned exp_lat);
    int unsigned n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int unsigned lat, input logic [31:0] elo,
                        input logic [31:0] ehi, input logic edbz);
    issue(op, x, y);
    wait_valid(tag, lat);
    check({tag, "_lo"}, 64'(bus.lo), 64'(elo));
    check({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
    check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
    step();
    check({tag, "_release"}, 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 2'd0;
    bus.x         = '0;
    bus.y         = '0;
    bus.kill      = 1'b0;
    bus.out_ready = 1'b1;

    step();
    step();
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_lo", 64'(bus.lo), 64'(0));
    check("rst_hi", 64'(bus.hi), 64'(0));
    check("rst_dbz", 64'(bus.div_by_zero), 64'(0));
    rst = 1'b0;
    step();

    // Multiplies
    run_op("mul_7x6",     2'd0, 32'd7,          32'd6,          33, 32'd42,         32'd0,          1'b0);
    run_op("mul_m1x2",    2'd0, 32'hFFFF_FFFF,  32'd2,          33, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0);
    run_op("mul_minxmin", 2'd0, 32'h8000_0000,  32'h8000_0000,  33, 32'h0000_0000,  32'h4000_0000,  1'b0);
    run_op("mul_m3x5",    2'd0, 32'hFFFF_FFFD,  32'd5,          33, 32'hFFFF_FFF1,  32'hFFFF_FFFF,  1'b0);
    run_op("mul_zero",    2'd0, 32'd12345,      32'd0,          33, 32'd0,          32'd0,          1'b0);
    run_op("mul_op3",     2'd3, 32'd3,          32'd4,          33, 32'd12,         32'd0,          1'b0);

    // Unsigned divides
    run_op("divu_big",    2'd1, 32'hFFFF_FFFF,  32'h10,         33, 32'h0FFF_FFFF,  32'hF,          1'b0);
    run_op("divu_min3",   2'd1, 32'h8000_0000,  32'd3,          33, 32'h2AAA_AAAA,  32'd2,          1'b0);
    run_op("divu_5by0",   2'd1, 32'd5,          32'd0,          1,  32'hFFFF_FFFF,  32'd5,          1'b1);
    run_op("div2_100by7", 2'd2, 32'd100,        32'd7,          33, 32'd14,         32'd2,          1'b0);

    // DIVU 100/7 with the consumer stalling for 5 cycles
    bus.out_ready = 1'b0;
    issue(2'd1, 32'd100, 32'd7);
    wait_valid("stall", 33);
    for (int i = 0; i < 5; i++) begin
      check("stall_lo", 64'(bus.lo), 64'(14));
      check("stall_hi", 64'(bus.hi), 64'(2));
      check("stall_valid", 64'(bus.out_valid), 64'(1));
      check("stall_in_ready", 64'(bus.in_ready), 64'(0));
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check("stall_release", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));

    // Kill a multiply mid-flight at cycle 10
    issue(2'd0, 32'd1000, 32'd1000);
    repeat (9) step();
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    check("kill_in_ready", 64'(bus.in_ready), 64'(1));
    check("kill_out_valid", 64'(bus.out_valid), 64'(0));
    check("kill_lo_kept", 64'(bus.lo), 64'(14));
    check("kill_hi_kept", 64'(bus.hi), 64'(2));
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        if (bus.out_valid === 1'b1) seen = 1'b1;
        step();
      end
      check("kill_no_valid", 64'(seen), 64'(0));
    end
    run_op("after_kill_9by3", 2'd1, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0);

    // kill takes priority over a simultaneous request
    bus.in_valid = 1'b1;
    bus.kill     = 1'b1;
    bus.op       = 2'd1;
    bus.x        = 32'd8;
    bus.y        = 32'd0;
    step();
    bus.in_valid = 1'b0;
    bus.kill     = 1'b0;
    check("killacc_in_ready", 64'(bus.in_ready), 64'(1));
    step();
    check("killacc_no_valid", 64'(bus.out_valid), 64'(0));

    // kill while a result is waiting in DONE
    bus.out_ready = 1'b0;
    issue(2'd1, 32'd5, 32'd0);
    wait_valid("killdone", 1);
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    bus.out_ready = 1'b1;
    check("killdone_state", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    check("killdone_lo_kept", 64'(bus.lo), 64'(32'hFFFF_FFFF));
    check("killdone_hi_kept", 64'(bus.hi), 64'(5));

    // Reset in the middle of an operation
    issue(2'd0, 32'd7, 32'd6);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_lo", 64'(bus.lo), 64'(0));
    check("midrst_hi", 64'(bus.hi), 64'(0));
    check("midrst_state", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    check("midrst_dbz", 64'(bus.div_by_zero), 64'(0));
    run_op("after_rst_m3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0);

`ifdef MULDIV_SIGNED_DIV_EN
    run_op("sdiv_m7by2",   2'd2, 32'hFFFF_FFF9, 32'd2,          33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("sdiv_7bym2",   2'd2, 32'd7,         32'hFFFF_FFFE,  33, 32'hFFFF_FFFD, 32'd1,         1'b0);
    run_op("sdiv_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  33, 32'h8000_0000, 32'd0,         1'b0);
    run_op("sdiv_by0",     2'd2, 32'hFFFF_FFF9, 32'd0,          1,  32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
`else
    run_op("op2_alias",    2'd2, 32'hFFFF_FFF9, 32'd2,          33, 32'h7FFF_FFFC, 32'd1,         1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
